// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial big-endian load/store sequencer; MISALIGN_TRAP_EN traps misaligned half/word instead of force-aligning
module load_store_unit #(
  parameter int ADDRESS_LENGTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [ADDRESS_LENGTH-1:0] mem_addr,
  output logic                      mem_we,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_next;
  logic [1:0] k, last, n_last;
  logic write, sgn, trap;
  logic [31:0] wbuf, rbuf, wload, full, ext;
  logic [ADDRESS_LENGTH-1:0] addr, base;
  // decode the incoming request: byte count, aligned base, left-justified store field, trap
  always_comb begin
    n_last = req_size[1] ? 2'd3 : req_size[0] ? 2'd1 : 2'd0;
    base = req_size[1] ? {req_addr[ADDRESS_LENGTH-1:2], 2'b00} :
           req_size[0] ? {req_addr[ADDRESS_LENGTH-1:1], 1'b0} : req_addr;
    wload = req_size[1] ? req_wdata : req_size[0] ? {req_wdata[15:0], 16'h0} : {req_wdata[7:0], 24'h0};
`ifdef MISALIGN_TRAP_EN
    trap = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
  end
  // assemble the final load value from the shifted-in bytes and extend it
  always_comb begin
    full = {rbuf[23:0], mem_rdata};
    ext = last == 2'd0 ? {sgn ? {24{full[7]}} : 24'h0, full[7:0]} :
          last == 2'd1 ? {sgn ? {16{full[15]}} : 16'h0, full[15:0]} : full;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = req_valid ? (trap ? RESP : ACCESS) : IDLE;
      ACCESS:  state_next = k == last ? RESP : ACCESS;
      default: state_next = IDLE;
    endcase
  end
  // request latch, byte walker and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      last <= '0;
      write <= 1'b0;
      sgn <= 1'b0;
      addr <= '0;
      wbuf <= '0;
      rbuf <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      k <= '0;
      last <= n_last;
      write <= req_write;
      sgn <= req_signed;
      addr <= base;
      wbuf <= wload;
      rbuf <= '0;
      resp_err <= trap;
      if (trap) resp_rdata <= '0;
    end else if (state == ACCESS) begin
      rbuf <= full;
      if (k == last) resp_rdata <= write ? 32'h0 : ext;
      else begin
        k <= k + 2'd1;
        addr <= addr + 1'b1;
        wbuf <= wbuf << 8;
      end
    end
  end
  assign req_ready = state == IDLE && !rst;
  assign resp_valid = state == RESP && !rst;
  assign mem_we = state == ACCESS && write && !rst;
  assign mem_addr = addr;
  assign mem_wdata = wbuf[31:24];
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a byte-array memory model
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [13:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [0:16383];
  int tests = 0, fails = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int lat, wes;
  logic [31:0] rd;
  logic err, rdy_busy, rdy_after;

  task automatic run(input logic w, input logic [1:0] sz, input logic sg, input logic [13:0] a,
                     input logic [31:0] wd);
    @(posedge clk) #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk) #1;
    req_valid = 1'b0;
    lat = -1; wes = 0; rd = 'x; err = 1'bx; rdy_busy = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      rdy_busy |= req_ready;
      if (mem_we) wes++;
      if (resp_valid) begin
        lat = i; rd = resp_rdata; err = resp_err;
        break;
      end
    end
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  logic [7:0] old31, old32, old33;

  initial begin
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 0);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_we", {31'b0, mem_we}, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", {31'b0, resp_err}, 0);
    check("rst_addr", {18'b0, mem_addr}, 0);
    check("rst_wdata", {24'b0, mem_wdata}, 0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready}, 1);

    run(1'b1, 2'b10, 1'b0, 14'h0010, 32'hDEADBEEF);
    check("sw_lat", lat, 5);
    check("sw_err", {31'b0, err}, 0);
    check("sw_we_count", wes, 4);
    check("sw_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);

    run(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_lat", lat, 5);
    check("lw_ready_busy", {31'b0, rdy_busy}, 0);
    check("lw_ready_after", {31'b0, rdy_after}, 1);
    check("lw_we_count", wes, 0);

    run(1'b0, 2'b00, 1'b1, 14'h0012, 32'h0);
    check("lb_data", rd, 32'hFFFFFFBE);
    check("lb_lat", lat, 2);
    run(1'b0, 2'b00, 1'b0, 14'h0012, 32'h0);
    check("lbu_data", rd, 32'h000000BE);

    run(1'b1, 2'b01, 1'b0, 14'h0020, 32'h00001234);
    check("sh_lat", lat, 3);
    check("sh_mem", {mem[32], mem[33]}, 16'h1234);
    check("sh_rdata_zero", rd, 0);
    run(1'b0, 2'b01, 1'b1, 14'h0020, 32'h0);
    check("lh_pos", rd, 32'h00001234);
    run(1'b0, 2'b01, 1'b1, 14'h0010, 32'h0);
    check("lh_neg", rd, 32'hFFFFDEAD);
    check("lh_lat", lat, 3);
    run(1'b0, 2'b01, 1'b0, 14'h0012, 32'h0);
    check("lhu_data", rd, 32'h0000BEEF);
    run(1'b0, 2'b11, 1'b0, 14'h0010, 32'h0);
    check("size11_data", rd, 32'hDEADBEEF);
    check("size11_lat", lat, 5);

    run(1'b0, 2'b10, 1'b0, 14'h0011, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("mis_lw_err", {31'b0, err}, 1);
    check("mis_lw_data", rd, 0);
    check("mis_lw_lat", lat, 1);
    run(1'b1, 2'b01, 1'b0, 14'h0013, 32'h0000AAAA);
    check("mis_sh_we", wes, 0);
    check("mis_sh_err", {31'b0, err}, 1);
`else
    check("mis_lw_err", {31'b0, err}, 0);
    check("mis_lw_data", rd, 32'hDEADBEEF);
    check("mis_lw_lat", lat, 5);
    run(1'b0, 2'b01, 1'b0, 14'h0013, 32'h0);
    check("mis_lh_data", rd, 32'h0000BEEF);
    check("mis_lh_lat", lat, 3);
`endif

    old31 = mem[49]; old32 = mem[50]; old33 = mem[51];
    @(posedge clk) #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 14'h0030; req_wdata = 32'h11223344;
    @(posedge clk) #1;
    req_valid = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", {31'b0, mem_we}, 0);
    check("abort_valid", {31'b0, resp_valid}, 0);
    check("abort_ready_in_rst", {31'b0, req_ready}, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'b0, req_ready}, 1);
    rdy_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy_busy |= resp_valid | mem_we;
    end
    check("abort_no_resp", {31'b0, rdy_busy}, 0);
    check("abort_mem30", {24'b0, mem[48]}, 32'h11);
    check("abort_mem31_33", {8'b0, mem[49], mem[50], mem[51]}, {8'b0, old31, old32, old33});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
